// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, forwarding encodings and the stage-enable bundle.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } stage_en_t;

   localparam stage_en_t EN_ALL  = stage_en_t'(5'b11111);
   localparam stage_en_t EN_NONE = stage_en_t'(5'b00000);
   localparam stage_en_t EN_LU   = stage_en_t'(5'b00111);

   // EX/MEM result is younger than MEM/WB, so it wins.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       mem_we,
      input logic [4:0] mem_wa,
      input logic       wb_we,
      input logic [4:0] wb_wa
   );
      logic mem_hit;
      logic wb_hit;
      mem_hit = mem_we && (mem_wa != REG_ZERO)
                && (mem_wa == src);
      wb_hit  = wb_we && (wb_wa != REG_ZERO)
                && (wb_wa == src);
      if (mem_hit)
         return FWD_EXMEM;
      else if (wb_hit)
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding select generation.
// Purely combinational; independent of the hazard FSM.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       mem_regwrite,
   input  logic [4:0] mem_waddr,
   input  logic       wb_regwrite,
   input  logic [4:0] wb_waddr,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   always_comb begin
      w_fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_waddr,
                        wb_regwrite, wb_waddr);
      w_fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_waddr,
                        wb_regwrite, wb_waddr);
   end

   assign fwd_a = w_fwd_a;
   assign fwd_b = w_fwd_b;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flushes, forwarding.
// HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_waddr,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_waddr,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_waddr,
   input  logic             redirect,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   localparam logic [3:0] FC_M1 = 4'(FLUSH_CYCLES - 1);
   localparam bit         MULTI = (FLUSH_CYCLES > 1);

   state_t     r_state;
   state_t     w_state_n;
   logic [3:0] r_flush_cnt;
   logic [3:0] w_flush_cnt_n;
   logic       r_redir_pend;
   logic       w_redir_pend_n;

   stage_en_t  w_en;
   logic       w_if_id_fl;
   logic       w_id_ex_fl;
   logic       w_lu;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;
   logic       w_unused;

   // Destination is not consulted: only loads create a
   // hazard that forwarding cannot cover.
   assign w_unused = ^{ex_regwrite, ex_waddr};

   assign w_lu = ex_memread && (ex_rt != REG_ZERO)
                 && ((ex_rt == id_rs)
                     || (id_uses_rt && (ex_rt == id_rt)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= RUN;
         r_flush_cnt  <= 4'd0;
         r_redir_pend <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_flush_cnt  <= w_flush_cnt_n;
         r_redir_pend <= w_redir_pend_n;
      end
   end

   always_comb begin
      w_en           = EN_ALL;
      w_if_id_fl     = 1'b0;
      w_id_ex_fl     = 1'b0;
      w_state_n      = r_state;
      w_flush_cnt_n  = r_flush_cnt;
      w_redir_pend_n = r_redir_pend;
      unique case (r_state)
         RUN: begin
            if (mem_busy) begin
               w_en      = EN_NONE;
               w_state_n = MEM_WAIT;
               if (redirect)
                  w_redir_pend_n = 1'b1;
            end else if (redirect) begin
               w_if_id_fl    = 1'b1;
               w_id_ex_fl    = 1'b1;
               w_flush_cnt_n = FC_M1;
               w_state_n     = MULTI ? FLUSH : RUN;
            end else if (w_lu) begin
               w_en       = EN_LU;
               w_id_ex_fl = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               w_en = EN_NONE;
               if (redirect)
                  w_redir_pend_n = 1'b1;
            end else if (r_redir_pend || redirect) begin
               w_if_id_fl     = 1'b1;
               w_id_ex_fl     = 1'b1;
               w_flush_cnt_n  = FC_M1;
               w_redir_pend_n = 1'b0;
               w_state_n      = MULTI ? FLUSH : RUN;
            end else begin
               w_state_n = RUN;
               if (w_lu) begin
                  w_en       = EN_LU;
                  w_id_ex_fl = 1'b1;
               end
            end
         end
         FLUSH: begin
            if (mem_busy) begin
               // Remaining flush is replayed in full after the wait.
               w_en           = EN_NONE;
               w_redir_pend_n = 1'b1;
               w_state_n      = MEM_WAIT;
            end else if (redirect) begin
               w_if_id_fl    = 1'b1;
               w_id_ex_fl    = 1'b1;
               w_flush_cnt_n = FC_M1;
               w_state_n     = MULTI ? FLUSH : RUN;
            end else begin
               w_if_id_fl = 1'b1;
               w_id_ex_fl = 1'b1;
               if (r_flush_cnt <= 4'd1) begin
                  w_flush_cnt_n = 4'd0;
                  w_state_n     = RUN;
               end else begin
                  w_flush_cnt_n = r_flush_cnt - 4'd1;
               end
            end
         end
         default: begin
            w_state_n = RUN;
         end
      endcase
   end

   pipe_fwd_unit u_fwd (
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .mem_regwrite (mem_regwrite),
      .mem_waddr    (mem_waddr),
      .wb_regwrite  (wb_regwrite),
      .wb_waddr     (wb_waddr),
      .fwd_a        (w_fwd_a),
      .fwd_b        (w_fwd_b)
   );

   // Pipeline runs freely while reset is held.
   assign pc_en       = w_en.pc     | ~reset_n;
   assign if_id_en    = w_en.if_id  | ~reset_n;
   assign id_ex_en    = w_en.id_ex  | ~reset_n;
   assign ex_mem_en   = w_en.ex_mem | ~reset_n;
   assign mem_wb_en   = w_en.mem_wb | ~reset_n;
   assign if_id_flush = w_if_id_fl  & reset_n;
   assign id_ex_flush = w_id_ex_fl  & reset_n;
   assign fwd_a       = reset_n ? w_fwd_a : FWD_REG;
   assign fwd_b       = reset_n ? w_fwd_b : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         if (!pc_en && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (id_ex_flush && (r_flush_cycles != '1))
            r_flush_cycles <= r_flush_cycles + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_cycles = r_flush_cycles;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2).
// Stimulus queues expectations; a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

   localparam logic [4:0] ALL  = 5'b11111;
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] LU   = 5'b00111;
   localparam logic [1:0] F0   = 2'b00;
   localparam logic [1:0] FF   = 2'b11;
   localparam logic [1:0] FB   = 2'b01;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_waddr;
   logic [4:0]  mem_waddr, wb_waddr;
   logic        id_uses_rt, ex_memread, ex_regwrite;
   logic        mem_regwrite, wb_regwrite, redirect, mem_busy;
   logic        pc_en, if_id_en, if_id_flush, id_ex_en;
   logic        id_ex_flush, ex_mem_en, mem_wb_en;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_cycles, flush_cycles;

   typedef struct {
      string       nm;
      logic [4:0]  en;
      logic [1:0]  fl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] e_stall = 0;
   logic [31:0] e_flush = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread),
      .ex_regwrite(ex_regwrite), .ex_waddr(ex_waddr),
      .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr),
      .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr),
      .redirect(redirect), .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
      .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
   );

   always @(negedge clk) begin
      exp_t       e;
      logic [4:0] a_en;
      if (q.size() != 0) begin
         e    = q.pop_front();
         a_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
         checks++;
         if (a_en !== e.en) begin
            errors++;
            $display("FAIL %s en got %b want %b", e.nm, a_en, e.en);
         end
         checks++;
         if ({if_id_flush, id_ex_flush} !== e.fl) begin
            errors++;
            $display("FAIL %s flush got %b want %b", e.nm,
                     {if_id_flush, id_ex_flush}, e.fl);
         end
         checks++;
         if ({fwd_a, fwd_b} !== {e.fa, e.fb}) begin
            errors++;
            $display("FAIL %s fwd got %b/%b want %b/%b", e.nm,
                     fwd_a, fwd_b, e.fa, e.fb);
         end
         checks++;
         if ({stall_cycles, flush_cycles} !== {e.sc, e.fc}) begin
            errors++;
            $display("FAIL %s cnt got %0d/%0d want %0d/%0d", e.nm,
                     stall_cycles, flush_cycles, e.sc, e.fc);
         end
      end
   end

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_memread = 0;
      ex_regwrite = 0; ex_waddr = 0;
      mem_regwrite = 0; mem_waddr = 0;
      wb_regwrite = 0; wb_waddr = 0;
      redirect = 0; mem_busy = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic want(input string nm, input logic [4:0] en,
                       input logic [1:0] fl, input logic [1:0] fa,
                       input logic [1:0] fb);
      exp_t e;
      e.nm = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
      e.sc = e_stall; e.fc = e_flush;
      q.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
      if (!en[4]) e_stall++;
      if (fl[0])  e_flush++;
`endif
   endtask

   task automatic set_lu();
      ex_memread = 1; ex_rt = 5; id_rs = 5;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset_n = 0;
      idle();
      tick();
      set_lu(); redirect = 1;
      mem_regwrite = 1; mem_waddr = 8; ex_rs = 8;
      want("rst", ALL, F0, 2'b00, 2'b00);
      tick(); reset_n = 1; idle();
      want("run", ALL, F0, 2'b00, 2'b00);
      // load-use on rs
      tick(); set_lu();
      want("lu", LU, FB, 2'b00, 2'b00);
      tick(); idle();
      want("lu_done", ALL, F0, 2'b00, 2'b00);
      // load-use on rt
      tick(); ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
      want("lu_rt", LU, FB, 2'b00, 2'b00);
      tick(); id_uses_rt = 0;
      want("lu_rt_nouse", ALL, F0, 2'b00, 2'b00);
      // redirect, lu ignored while flushing
      tick(); idle(); redirect = 1;
      want("redir1", ALL, FF, 2'b00, 2'b00);
      tick(); idle(); set_lu();
      want("redir2", ALL, FF, 2'b00, 2'b00);
      tick(); idle();
      want("redir_end", ALL, F0, 2'b00, 2'b00);
      // busy 3 cycles, redirect in cycle 2
      tick(); mem_busy = 1;
      want("busy1", NONE, F0, 2'b00, 2'b00);
      tick(); redirect = 1;
      want("busy2", NONE, F0, 2'b00, 2'b00);
      tick(); redirect = 0;
      want("busy3", NONE, F0, 2'b00, 2'b00);
      tick(); idle();
      want("pend1", ALL, FF, 2'b00, 2'b00);
      tick();
      want("pend2", ALL, FF, 2'b00, 2'b00);
      tick();
      want("pend_end", ALL, F0, 2'b00, 2'b00);
      // redirect during FLUSH reloads the count
      tick(); redirect = 1;
      want("rl1", ALL, FF, 2'b00, 2'b00);
      tick();
      want("rl2", ALL, FF, 2'b00, 2'b00);
      tick(); idle();
      want("rl3", ALL, FF, 2'b00, 2'b00);
      tick();
      want("rl_end", ALL, F0, 2'b00, 2'b00);
      // busy during FLUSH replays the flush
      tick(); redirect = 1;
      want("fb1", ALL, FF, 2'b00, 2'b00);
      tick(); idle(); mem_busy = 1;
      want("fb_busy", NONE, F0, 2'b00, 2'b00);
      tick(); idle();
      want("fb2", ALL, FF, 2'b00, 2'b00);
      tick();
      want("fb3", ALL, FF, 2'b00, 2'b00);
      tick();
      want("fb_end", ALL, F0, 2'b00, 2'b00);
      // busy and redirect together, then lu on wait exit
      tick(); mem_busy = 1; redirect = 1;
      want("br1", NONE, F0, 2'b00, 2'b00);
      tick(); idle();
      want("br2", ALL, FF, 2'b00, 2'b00);
      tick();
      want("br3", ALL, FF, 2'b00, 2'b00);
      tick(); mem_busy = 1;
      want("bl1", NONE, F0, 2'b00, 2'b00);
      tick(); idle(); set_lu();
      want("bl2", LU, FB, 2'b00, 2'b00);
      tick(); idle();
      want("bl3", ALL, F0, 2'b00, 2'b00);
      // forwarding
      tick(); mem_regwrite = 1; wb_regwrite = 1;
      mem_waddr = 8; wb_waddr = 8; ex_rs = 8; ex_rt = 0;
      want("fwd_pri", ALL, F0, 2'b10, 2'b00);
      tick(); mem_regwrite = 0;
      want("fwd_wb", ALL, F0, 2'b01, 2'b00);
      tick(); mem_regwrite = 1; mem_waddr = 3;
      ex_rs = 3; ex_rt = 8;
      want("fwd_ab", ALL, F0, 2'b10, 2'b01);
      // register zero guards
      tick(); idle(); ex_memread = 1; ex_rt = 0; id_rs = 0;
      mem_regwrite = 1; mem_waddr = 0; ex_rs = 0;
      wb_regwrite = 1; wb_waddr = 0;
      want("zero", ALL, F0, 2'b00, 2'b00);
      // reset in the middle of a flush
      tick(); idle(); redirect = 1;
      want("rf1", ALL, FF, 2'b00, 2'b00);
      tick(); idle(); reset_n = 0;
      e_stall = 0; e_flush = 0;
      want("rf_rst", ALL, F0, 2'b00, 2'b00);
      tick(); reset_n = 1;
      want("rf_after", ALL, F0, 2'b00, 2'b00);
      tick();
      tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
